alu_seq: RTL and testbench

//  Parametrised multi-cycle successor to the 4-bit slice ALU. The datapath processes WIDTH-bit operands as
//  4-bit slices, SLICES per clock, with the carry rippled between cycles. Adds optional packed-BCD adjust,
//  6502-style flags (N V Z C), and valid/ready handshakes. Sits between the operand latches and the

---
 rtl/alu_seq.sv | 196 +++++++++++++++++++
 tb/tb_alu_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle slice ALU: WIDTH-bit operands processed as 4-bit slices, SLICES per clock,
// with rippled carry, optional packed-BCD adjust, N/V/Z/C flags and valid/ready handshakes.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int SLICES = 1,
  parameter bit DEC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             m,
  input  logic [3:0]       s,
  input  logic             d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             co,
  output logic             v,
  output logic             n,
  output logic             z
);

  localparam int NSTEP  = WIDTH / (4 * SLICES);
  localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [3:0] f;
    logic       co;
    logic       v;
  } slice_t;

  // One 4-bit slice. Arithmetic uses the classic decomposition
  // F = (A | B&S0 | ~B&S1) + (A&~B&S2 | A&B&S3) + cin, which covers the whole table.
  function automatic slice_t slice_eval(
    input logic [3:0] na,
    input logic [3:0] nb,
    input logic       cin,
    input logic       arith,
    input logic [3:0] sel,
    input logic       dec
  );
    slice_t     r;
    logic [3:0] t1;
    logic [3:0] t2;
    logic [4:0] sum;
    logic [3:0] low3;
    r    = '0;
    t1   = na | (nb & {4{sel[0]}}) | (~nb & {4{sel[1]}});
    t2   = (na & ~nb & {4{sel[2]}}) | (na & nb & {4{sel[3]}});
    sum  = {1'b0, t1} + {1'b0, t2} + {4'b0, cin};
    low3 = {1'b0, t1[2:0]} + {1'b0, t2[2:0]} + {3'b0, cin};
    if (!arith) begin
      case (sel)
        4'b0000: r.f = ~na;
        4'b0001: r.f = ~(na | nb);
        4'b0010: r.f = ~na & nb;
        4'b0011: r.f = 4'h0;
        4'b0100: r.f = ~(na & nb);
        4'b0101: r.f = ~nb;
        4'b0110: r.f = na ^ nb;
        4'b0111: r.f = na & ~nb;
        4'b1000: r.f = ~na | nb;
        4'b1001: r.f = ~(na ^ nb);
        4'b1010: r.f = nb;
        4'b1011: r.f = na & nb;
        4'b1100: r.f = 4'hF;
        4'b1101: r.f = na | ~nb;
        4'b1110: r.f = na | nb;
        default: r.f = na;
      endcase
    end else begin
      r.f  = sum[3:0];
      r.co = sum[4];
      // Overflow always reflects the unadjusted binary sum.
      r.v  = low3[3] ^ sum[4];
      if (dec && sel[3]) begin
        if (sum > 5'd9) begin
          r.f  = sum[3:0] + 4'd6;
          r.co = 1'b1;
        end
      end else if (dec) begin
        if (!sum[4]) begin
          r.f  = sum[3:0] - 4'd6;
          r.co = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, f_q, f_nxt;
  logic [3:0]         s_q;
  logic               m_q, d_q, carry_q;
  logic [STEP_W-1:0]  step_q;
  logic               co_q, v_q, n_q, z_q;
  logic               c_chain, v_top, dec_act, last_step;
  slice_t             r;
  int                 base;

  assign dec_act   = DEC_EN && d_q && m_q && (s_q == 4'b1001 || s_q == 4'b0110);
  assign last_step = (step_q == STEP_W'(NSTEP - 1));

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    f_nxt   = f_q;
    c_chain = carry_q;
    v_top   = 1'b0;
    r       = '0;
    base    = 0;
    for (int k = 0; k < SLICES; k++) begin
      base    = (int'(step_q) * SLICES + k) * 4;
      r       = slice_eval(a_q[base +: 4], b_q[base +: 4], c_chain, m_q, s_q, dec_act);
      f_nxt[base +: 4] = r.f;
      c_chain = r.co;
      v_top   = r.v;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Operand latches and result registers; reset clears everything so an abandoned
  // operation leaves nothing visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      d_q     <= 1'b0;
      carry_q <= 1'b0;
      step_q  <= '0;
      f_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          s_q     <= s;
          m_q     <= m;
          d_q     <= d;
          carry_q <= ci;
          step_q  <= '0;
        end
        RUN: begin
          f_q     <= f_nxt;
          carry_q <= c_chain;
          step_q  <= step_q + 1'b1;
          if (last_step) begin
            co_q <= m_q & c_chain;
            v_q  <= m_q & v_top;
            n_q  <= f_nxt[WIDTH-1];
            z_q  <= (f_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign f  = f_q;
  assign co = co_q;
  assign v  = v_q;
  assign n  = n_q;
  assign z  = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: binary/decimal arithmetic, logic, latency,
// backpressure and asynchronous reset, with a second instance built with SLICES=2.
module tb_alu_seq;

  logic       clk, rst_n;
  logic       in_valid, in_valid2, out_ready, out_ready2;
  logic [7:0] a, b;
  logic       ci, m, d;
  logic [3:0] s;
  logic       in_ready, out_valid, co, v, n, z;
  logic [7:0] f;
  logic       in_ready2, out_valid2, co2, v2, n2, z2;
  logic [7:0] f2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  alu_seq #(.WIDTH(8), .SLICES(1), .DEC_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .m(m), .s(s), .d(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .co(co), .v(v), .n(n), .z(z)
  );

  alu_seq #(.WIDTH(8), .SLICES(2), .DEC_EN(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a), .b(b), .ci(ci), .m(m), .s(s), .d(d),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .f(f2), .co(co2), .v(v2), .n(n2), .z(z2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                        input logic tm, input logic [3:0] ts, input logic td);
    @(negedge clk);
    a = ta; b = tb; ci = tci; m = tm; s = ts; d = td;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    out_ready = 1'b0; out_ready2 = 1'b0;
    a = '0; b = '0; ci = 1'b0; m = 1'b0; s = '0; d = 1'b0;

    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_f", f, 8'h00);
    check("rst_flags", {co, v, n, z}, 4'b0000);
    @(negedge clk) rst_n = 1'b1;

    // T1: binary add with signed overflow
    accept(8'h7F, 8'h01, 1'b0, 1'b1, 4'b1001, 1'b0);
    check("t1_busy", in_ready, 1'b0);
    wait_result("t1", 2);
    check("t1_f", f, 8'h80);
    check("t1_flags", {co, v, n, z}, 4'b0110);
    release_result("t1");
    check("t1_hold_f", f, 8'h80);

    // T2: decimal add
    accept(8'h45, 8'h38, 1'b0, 1'b1, 4'b1001, 1'b1);
    wait_result("t2a", 2);
    check("t2a_f", f, 8'h83);
    check("t2a_co_z", {co, z}, 2'b00);
    release_result("t2a");
    accept(8'h99, 8'h01, 1'b0, 1'b1, 4'b1001, 1'b1);
    wait_result("t2b", 2);
    check("t2b_f", f, 8'h00);
    check("t2b_co_n_z", {co, n, z}, 3'b101);
    release_result("t2b");

    // T3: decimal subtract
    accept(8'h10, 8'h01, 1'b1, 1'b1, 4'b0110, 1'b1);
    wait_result("t3a", 2);
    check("t3a_f", f, 8'h09);
    check("t3a_co", co, 1'b1);
    release_result("t3a");
    accept(8'h00, 8'h01, 1'b1, 1'b1, 4'b0110, 1'b1);
    wait_result("t3b", 2);
    check("t3b_f", f, 8'h99);
    check("t3b_co_n", {co, n}, 2'b01);
    release_result("t3b");

    // T4: logic XOR, carries suppressed
    accept(8'hF0, 8'h3C, 1'b1, 1'b0, 4'b0110, 1'b0);
    wait_result("t4", 2);
    check("t4_f", f, 8'hCC);
    check("t4_flags", {co, v, n, z}, 4'b0010);
    release_result("t4");

    // T4b: same operation on the two-slice instance, one-cycle latency
    @(negedge clk) in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    cyc = 0;
    while (!out_valid2 && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("t4b_latency", cyc, 1);
    check("t4b_f", f2, 8'hCC);
    check("t4b_flags", {co2, v2, n2, z2}, 4'b0010);
    @(negedge clk) out_ready2 = 1'b1;
    @(posedge clk);
    #1 out_ready2 = 1'b0;
    check("t4b_ready_back", in_ready2, 1'b1);

    // T5: backpressure; a second request waits until the block is idle again
    accept(8'h12, 8'h34, 1'b0, 1'b1, 4'b1001, 1'b0);
    wait_result("t5", 2);
    @(negedge clk);
    a = 8'h05; b = 8'h03; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t5_stall_valid", out_valid, 1'b1);
      check("t5_stall_ready", in_ready, 1'b0);
      check("t5_stall_f", f, 8'h46);
    end
    check("t5_stall_flags", {co, v, n, z}, 4'b0000);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("t5_release_valid", out_valid, 1'b0);
    check("t5_release_ready", in_ready, 1'b1);
    check("t5_release_f", f, 8'h46);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("t5_second_taken", in_ready, 1'b0);
    wait_result("t5b", 2);
    check("t5b_f", f, 8'h08);
    release_result("t5b");

    // T6: reset during RUN abandons the operation
    accept(8'hFF, 8'h01, 1'b0, 1'b1, 4'b1001, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_f", f, 8'h00);
    check("t6_in_ready", in_ready, 1'b1);
    check("t6_flags", {co, v, n, z}, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    accept(8'h01, 8'h01, 1'b0, 1'b1, 4'b1001, 1'b0);
    wait_result("t6b", 2);
    check("t6b_f", f, 8'h02);
    check("t6b_co", co, 1'b0);
    release_result("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
